// File: rtl/store_buffer_if.sv
// Bundles the MEM-side request signals and the data-memory port of the store buffer.
// The slave modport is the buffer itself; master is the pipeline/memory environment.
interface store_buffer_if #(
  parameter int unsigned PTR_W = 2
);
  logic             MemWrite_IN;
  logic             MemRead_IN;
  logic [31:0]      Address_IN;
  logic [31:0]      WriteData_IN;
  logic [1:0]       WriteSize_IN;
  logic             Flush_IN;
  logic             DM_Ready_IN;
  logic [31:0]      DM_ReadData_IN;
  logic [31:0]      DM_Address_OUT;
  logic [31:0]      DM_WriteData_OUT;
  logic [1:0]       DM_WriteSize_OUT;
  logic             DM_MemRead_OUT;
  logic             DM_MemWrite_OUT;
  logic [31:0]      ReadData_OUT;
  logic             Stall_OUT;
  logic [PTR_W:0]   Count_OUT;

  modport slave (
    input  MemWrite_IN, MemRead_IN, Address_IN, WriteData_IN, WriteSize_IN,
           Flush_IN, DM_Ready_IN, DM_ReadData_IN,
    output DM_Address_OUT, DM_WriteData_OUT, DM_WriteSize_OUT, DM_MemRead_OUT,
           DM_MemWrite_OUT, ReadData_OUT, Stall_OUT, Count_OUT
  );

  modport master (
    output MemWrite_IN, MemRead_IN, Address_IN, WriteData_IN, WriteSize_IN,
           Flush_IN, DM_Ready_IN, DM_ReadData_IN,
    input  DM_Address_OUT, DM_WriteData_OUT, DM_WriteSize_OUT, DM_MemRead_OUT,
           DM_MemWrite_OUT, ReadData_OUT, Stall_OUT, Count_OUT
  );
endinterface

// File: rtl/store_buffer.sv
// Store FIFO between the MEM stage and the data-memory port: buffers stores, drains one
// per free/ready cycle, passes loads through, and stalls on full, conflict or flush.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic         CLK,
  input  logic         RESET,
  store_buffer_if.slave bus
);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_EMPTY, ST_HOLD, ST_FLUSH} state_t;

  state_t             state, state_n;
  logic [PTR_W-1:0]   head, tail;
  logic [CNT_W-1:0]   count, count_n;
  logic [DEPTH-1:0]   valid;
  logic [31:0]        addr_q [DEPTH];
  logic [31:0]        data_q [DEPTH];
  logic [1:0]         size_q [DEPTH];

  logic wr, rd, conflict, load_go, drain, accept, flush_req, not_full;

  // Word-granular match of the load address against every live entry
  always_comb begin
    conflict = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[PTR_W'(i)] && (addr_q[PTR_W'(i)][31:2] == bus.Address_IN[31:2]))
        conflict = 1'b1;
    end
  end

  // A simultaneous read and write is treated as a store only
  assign wr        = bus.MemWrite_IN;
  assign rd        = bus.MemRead_IN & ~bus.MemWrite_IN;
  assign load_go   = rd & ~conflict & RESET;
  assign drain     = (count != '0) & bus.DM_Ready_IN & ~load_go;
  assign flush_req = (state == ST_FLUSH) | (bus.Flush_IN & (count != '0));
  assign not_full  = (count != CNT_W'(DEPTH));
  // A store is held back while a flush is pending so a stalled store is not captured twice
  assign accept    = wr & ~flush_req & (not_full | drain);
  assign count_n   = count + CNT_W'(accept) - CNT_W'(drain);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= ST_EMPTY;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      if (drain) begin
        head        <= head + PTR_W'(1);
        valid[head] <= 1'b0;
      end
      // Ordered after the drain clear so a full-and-draining slot stays valid
      if (accept) begin
        tail        <= tail + PTR_W'(1);
        valid[tail] <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      addr_q[tail] <= bus.Address_IN;
      data_q[tail] <= bus.WriteData_IN;
      size_q[tail] <= bus.WriteSize_IN;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_EMPTY: begin
        if (accept) state_n = ST_HOLD;
      end
      ST_HOLD: begin
        if (count_n == '0)       state_n = ST_EMPTY;
        else if (bus.Flush_IN)   state_n = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (count_n == '0) state_n = ST_EMPTY;
      end
      default: state_n = ST_EMPTY;
    endcase
  end

  // Port mux: drain owns the port only when no load does
  assign bus.DM_Address_OUT   = !RESET ? 32'h0 : (drain ? addr_q[head] : bus.Address_IN);
  assign bus.DM_WriteData_OUT = drain ? data_q[head] : 32'h0;
  assign bus.DM_WriteSize_OUT = drain ? size_q[head] : 2'd0;
  assign bus.DM_MemRead_OUT   = load_go;
  assign bus.DM_MemWrite_OUT  = drain;
  assign bus.ReadData_OUT     = bus.DM_ReadData_IN;
  assign bus.Stall_OUT        = RESET & ((wr & ~accept) | (rd & conflict) | flush_req);
  assign bus.Count_OUT        = count;
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits between the MEM stage and the data-memory port, and owns that port.
- Absorbs stores from MEM into a small FIFO and drains them to data memory one per cycle, when the port is free and memory is ready.
- Passes loads straight through; stalls the pipeline on a buffer-full condition, a load/store address conflict, or a flush request.

Parameters:
DEPTH, 4, number of buffered store entries (power of two, >=2)
PTR_W, 2, log2(DEPTH)

Ports:
CLK  input  1  clock
RESET  input  1  asynchronous, active-low reset
MemWrite_IN  input  1  MEM requests a store this cycle
MemRead_IN  input  1  MEM requests a load this cycle
Address_IN  input  32  store address (may be unaligned) / load address (word-aligned)
WriteData_IN  input  32  store data, already merged by MEM
WriteSize_IN  input  2  0=word, 1=byte, 2=half, 3=three bytes
Flush_IN  input  1  drain all entries before continuing (syscall/halt)
DM_Ready_IN  input  1  data memory accepts a write this cycle
DM_ReadData_IN  input  32  data memory read data
DM_Address_OUT  output  32  address to data memory
DM_WriteData_OUT  output  32  write data to data memory
DM_WriteSize_OUT  output  2  write size to data memory
DM_MemRead_OUT  output  1  read strobe
DM_MemWrite_OUT  output  1  write strobe
ReadData_OUT  output  32  load data returned to MEM
Stall_OUT  output  1  hold MEM and upstream stages this cycle
Count_OUT  output  PTR_W+1  current occupancy

Behaviour:
- Reset (async, RESET low):
  - Head, tail and count are cleared to 0; state goes to EMPTY; entry valid bits are cleared.
  - All outputs read 0: DM strobes, Stall_OUT, Count_OUT, DM address/data/size.
  - A reset mid-drain discards all entries; no partial write is issued after RESET falls.
- States and transitions:
  - EMPTY: count==0.
  - HOLD: count>0, no flush pending.
  - FLUSH: Flush_IN seen with count>0.
  - EMPTY->HOLD on an accepted store.
  - HOLD->EMPTY when the last entry drains and no store is accepted that cycle.
  - EMPTY or HOLD -> FLUSH when Flush_IN=1 and count>0. With Flush_IN=1 and count==0 the block stays in EMPTY and Stall_OUT=0.
  - FLUSH->EMPTY when count reaches 0.
- Load path (combinational):
  - DM_MemRead_OUT=MemRead_IN & ~conflict; DM_Address_OUT=Address_IN; ReadData_OUT=DM_ReadData_IN.
  - conflict = any valid entry whose Address[31:2] equals Address_IN[31:2].
- Port arbitration: a non-conflicting load owns the DM port for that cycle. A drain happens only in cycles with no DM read.
- Drain:
  - The drain condition is count>0, DM_Ready_IN=1 and the port is not used by a load.
  - When it holds, the head entry is driven on DM_Address/WriteData/WriteSize with DM_MemWrite_OUT=1, and head advances at the clock edge.
  - The head entry's address is driven unmodified; unaligned stores reach memory as presented.
- Enqueue:
  - A store is accepted at the clock edge when MemWrite_IN=1, state!=FLUSH, and (count<DEPTH or a drain occurs that same cycle).
  - Accept and drain in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- Stall_OUT=1 in any of these cases:
  - MemWrite_IN and the store is not accepted (full with no drain, or FLUSH);
  - MemRead_IN and conflict;
  - state==FLUSH, or Flush_IN with count>0.
- Simultaneous MemRead_IN and MemWrite_IN is illegal. Handle it as a store only; the read strobe is suppressed.
- Ordering: entries drain strictly FIFO; there is no write combining.
- Count_OUT is registered and equals the occupancy after the most recent edge.

Test Plan:
- Reset with 3 entries queued -> Count_OUT=0, DM_MemWrite_OUT=0 immediately; no write to memory after RESET rises.
- 4 stores to 0x100,0x104,0x108,0x10C with DM_Ready_IN=0 -> Count_OUT=4. A 5th store -> Stall_OUT=1. Raise DM_Ready_IN -> 0x100 writes first and the 5th store is accepted that cycle; Count_OUT stays 4.
- Store 0xDEADBEEF to 0x203 size=1, then load 0x200 with DM_Ready_IN=0 -> Stall_OUT=1, DM_MemRead_OUT=0. Ready=1 -> write drains, then the load proceeds next cycle.
- Load 0x300 (no conflict) while 2 entries are queued and DM_Ready_IN=1 -> the read is issued, no write that cycle, Count_OUT unchanged; the drain resumes the following cycle.
- Flush_IN pulse with 3 entries -> Stall_OUT=1 for 3 cycles (Ready=1), three writes in FIFO order, then state EMPTY and Stall_OUT=0.
- Eight back-to-back stores with Ready=1 -> the pointers wrap twice, all eight addresses appear on the DM port in order, and there is never a stall.
